// File: rtl/seg_scan_controller_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Used by the controller and its glyph decoder.
package seg_scan_controller_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam int NUM_ELEMS = 4;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Element order on the display differs from bus byte order.
  function automatic logic [3:0] elem_sel(
    input logic [15:0] c,
    input logic [1:0]  i
  );
    logic [3:0] e;
    unique case (i)
      2'd0:    e = c[11:8];
      2'd1:    e = c[15:12];
      2'd2:    e = c[3:0];
      default: e = c[7:4];
    endcase
    return e;
  endfunction

endpackage

// File: rtl/seg_scan_controller_seg7_decoder.sv
// Hex-nibble to 7-segment glyph, bit0=a .. bit6=g, active-high.
// Only 0..8 have glyphs; everything else is blank.
module seg7_decoder
  import seg_scan_controller_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  // Glyph lookup.
  always_comb begin
    seg = SEG_BLANK;
    unique case (value)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Scans a 2x2 matrix snapshot onto one 7-segment display.
// Optional macro SEG_SCAN_DP_EN: dp marks digit 0 of each frame.
module seg_scan_controller
  import seg_scan_controller_pkg::*;
#(
  parameter int DWELL_CYCLES = 8,
  parameter int BLANK_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_valid,
  output logic        c_ready,
  input  logic [15:0] c_data,
  input  logic        hold,
  output logic [6:0]  seg,
  output logic [1:0]  digit_idx,
  output logic        dp,
  output logic        busy
);

  localparam logic [CNT_W-1:0] DWELL_LAST =
    CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST =
    CNT_W'(BLANK_CYCLES - 1);
  localparam logic [1:0] LAST_IDX =
    2'(NUM_ELEMS - 1);

  state_t            state;
  state_t            state_nx;
  logic [1:0]        idx_nx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nx;
  logic [15:0]       snap;
  logic [15:0]       snap_nx;
  logic [3:0]        elem;
  logic [6:0]        glyph;
  logic              fire;

  // Ready in IDLE and on the last blank cycle before wrap.
  assign c_ready = (state == IDLE) ||
                   (state == BLANK &&
                    digit_idx == LAST_IDX &&
                    cnt == BLANK_LAST);

  assign fire = c_valid && c_ready;
  assign busy = (state != IDLE);

  // Next state; a handshake overrides hold.
  always_comb begin
    state_nx = state;
    idx_nx   = digit_idx;
    cnt_nx   = cnt;
    snap_nx  = snap;
    if (fire) begin
      snap_nx  = c_data;
      idx_nx   = 2'd0;
      cnt_nx   = '0;
      state_nx = SHOW;
    end else if (!hold) begin
      unique case (state)
        IDLE: state_nx = IDLE;
        SHOW: begin
          if (cnt == DWELL_LAST) begin
            cnt_nx   = '0;
            state_nx = BLANK;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt_nx   = '0;
            state_nx = SHOW;
            if (digit_idx == LAST_IDX)
              idx_nx = 2'd0;
            else
              idx_nx = digit_idx + 2'd1;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign elem = elem_sel(snap_nx, idx_nx);

  seg7_decoder u_dec (
    .value (elem),
    .seg   (glyph)
  );

  // State, snapshot and registered segment drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      digit_idx <= 2'd0;
      cnt       <= '0;
      snap      <= 16'h0000;
      seg       <= SEG_BLANK;
    end else begin
      state     <= state_nx;
      digit_idx <= idx_nx;
      cnt       <= cnt_nx;
      snap      <= snap_nx;
      seg       <= (state_nx == SHOW) ? glyph : SEG_BLANK;
    end
  end

`ifdef SEG_SCAN_DP_EN
  // Decimal point flags the first element of the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dp <= 1'b0;
    else
      dp <= (state_nx == SHOW) && (idx_nx == 2'd0);
  end
`else
  assign dp = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_controller.sv
// Self-checking bench for seg_scan_controller.
// Model tracks scan position as an index into the frame.
module tb_seg_scan_controller;

  localparam int D = 4;
  localparam int B = 1;
  localparam int S = D + B;
  localparam int P = 4 * S;

  logic        clk;
  logic        rst_n;
  logic        c_valid;
  logic        c_ready;
  logic [15:0] c_data;
  logic        hold;
  logic [6:0]  seg;
  logic [1:0]  digit_idx;
  logic        dp;
  logic        busy;

  int total;
  int bad;

  bit          m_busy;
  int          m_n;
  logic [15:0] m_snap;
  bit          m_hs;

  seg_scan_controller #(
    .DWELL_CYCLES (D),
    .BLANK_CYCLES (B),
    .CNT_W        (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .c_valid   (c_valid),
    .c_ready   (c_ready),
    .c_data    (c_data),
    .hold      (hold),
    .seg       (seg),
    .digit_idx (digit_idx),
    .dp        (dp),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [3:0] nib(input int d);
    case (d)
      0: return m_snap[11:8];
      1: return m_snap[15:12];
      2: return m_snap[3:0];
      default: return m_snap[7:4];
    endcase
  endfunction

  function automatic int m_dig();
    return m_busy ? (m_n / S) : 0;
  endfunction

  function automatic bit m_show();
    return m_busy && ((m_n % S) < D);
  endfunction

  function automatic logic [6:0] exp_seg();
    return m_show() ? glyph(nib(m_dig())) : 7'h00;
  endfunction

  function automatic logic [1:0] exp_idx();
    return 2'(m_dig());
  endfunction

  function automatic logic exp_ready();
    return !m_busy || (m_n == P - 1);
  endfunction

  function automatic logic exp_dp();
`ifdef SEG_SCAN_DP_EN
    return m_show() && (m_dig() == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic cycle();
    bit hs;
    logic [15:0] d;
    hs = exp_ready() && c_valid;
    d = c_data;
    @(posedge clk);
    m_hs = hs;
    if (hs) begin
      m_busy = 1'b1;
      m_n = 0;
      m_snap = d;
    end else if (m_busy && !hold) begin
      m_n = (m_n + 1) % P;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    m_busy = 1'b0;
    m_n = 0;
    m_snap = 16'h0000;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    c_valid = 1'b0;
    c_data = 16'h0000;
    hold = 1'b0;
    do_reset();
    total++;
    if (seg !== 7'h00 || digit_idx !== 2'd0) begin
      bad++;
      $display("FAIL reset_seg seg=%b idx=%0d want 0/0",
               seg, digit_idx);
    end
    total++;
    if (busy !== 1'b0 || c_ready !== 1'b1 || dp !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl busy=%b rdy=%b dp=%b want 0/1/0",
               busy, c_ready, dp);
    end
  endtask

  task automatic test_scan();
    c_data = 16'h2103;
    c_valid = 1'b1;
    cycle();
    c_valid = 1'b0;
    total++;
    if (seg !== 7'b0000110 || digit_idx !== 2'd0 || !busy) begin
      bad++;
      $display("FAIL scan_first seg=%b idx=%0d busy=%b want 0000110/0/1",
               seg, digit_idx, busy);
    end
    for (int i = 0; i < 2 * P; i++) begin
      cycle();
      total++;
      if (seg !== exp_seg() || digit_idx !== exp_idx() ||
          c_ready !== exp_ready() || dp !== exp_dp()) begin
        bad++;
        $display("FAIL scan_%0d seg=%b idx=%0d rdy=%b dp=%b want %b/%0d/%b/%b",
                 i, seg, digit_idx, c_ready, dp,
                 exp_seg(), exp_idx(), exp_ready(), exp_dp());
      end
    end
  endtask

  task automatic test_out_of_range();
    bit seen3;
    seen3 = 1'b0;
    do_reset();
    c_data = 16'h00F0;
    c_valid = 1'b1;
    cycle();
    c_valid = 1'b0;
    for (int i = 0; i < P; i++) begin
      if (m_show() && m_dig() == 3) begin
        seen3 = 1'b1;
        total++;
        if (seg !== 7'h00 || digit_idx !== 2'd3) begin
          bad++;
          $display("FAIL oor_digit3 seg=%b idx=%0d want 0/3",
                   seg, digit_idx);
        end
      end else begin
        total++;
        if (seg !== exp_seg() || digit_idx !== exp_idx()) begin
          bad++;
          $display("FAIL oor_%0d seg=%b idx=%0d want %b/%0d",
                   i, seg, digit_idx, exp_seg(), exp_idx());
        end
      end
      cycle();
    end
    total++;
    if (!seen3) begin
      bad++;
      $display("FAIL oor_reach3 seen=0 want 1");
    end
  endtask

  task automatic test_reload();
    bit done;
    done = 1'b0;
    c_data = 16'h0500;
    c_valid = 1'b1;
    for (int i = 0; i < 2 * P && !done; i++) begin
      total++;
      if (c_ready !== exp_ready()) begin
        bad++;
        $display("FAIL reload_rdy_%0d rdy=%b want %b",
                 i, c_ready, exp_ready());
      end
      cycle();
      done = m_hs;
    end
    c_valid = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL reload_timeout hs=0 want 1");
    end
    total++;
    if (seg !== 7'b1101101 || digit_idx !== 2'd0) begin
      bad++;
      $display("FAIL reload_first seg=%b idx=%0d want 1101101/0",
               seg, digit_idx);
    end
    for (int i = 0; i < P; i++) begin
      cycle();
      total++;
      if (seg !== exp_seg() || digit_idx !== exp_idx()) begin
        bad++;
        $display("FAIL reload_%0d seg=%b idx=%0d want %b/%0d",
                 i, seg, digit_idx, exp_seg(), exp_idx());
      end
    end
  endtask

  task automatic test_hold();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * P && !found; i++) begin
      if (m_busy && m_n == S + 1) found = 1'b1;
      else cycle();
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL hold_find found=0 want 1");
    end
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      total++;
      if (seg !== glyph(m_snap[15:12]) || digit_idx !== 2'd1 ||
          m_n != S + 1) begin
        bad++;
        $display("FAIL hold_%0d seg=%b idx=%0d want %b/1",
                 i, seg, digit_idx, glyph(m_snap[15:12]));
      end
    end
    hold = 1'b0;
    for (int i = 0; i < P; i++) begin
      cycle();
      total++;
      if (seg !== exp_seg() || digit_idx !== exp_idx()) begin
        bad++;
        $display("FAIL hold_resume_%0d seg=%b idx=%0d want %b/%0d",
                 i, seg, digit_idx, exp_seg(), exp_idx());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      c_valid = ($urandom_range(0, 9) < 3);
      hold = ($urandom_range(0, 9) < 2);
      c_data = 16'($urandom);
      cycle();
      total++;
      if (seg !== exp_seg() || digit_idx !== exp_idx() ||
          busy !== m_busy || c_ready !== exp_ready() ||
          dp !== exp_dp()) begin
        bad++;
        $display("FAIL rand_%0d seg=%b idx=%0d busy=%b rdy=%b dp=%b want %b/%0d/%b/%b/%b",
                 i, seg, digit_idx, busy, c_ready, dp,
                 exp_seg(), exp_idx(), m_busy, exp_ready(), exp_dp());
      end
    end
    c_valid = 1'b0;
    hold = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    if (!m_busy) begin
      c_data = 16'h8765;
      c_valid = 1'b1;
      cycle();
      c_valid = 1'b0;
    end
    for (int i = 0; i < 2 * P && !found; i++) begin
      if (m_busy && m_dig() == 2 && !m_show()) found = 1'b1;
      else cycle();
    end
    total++;
    if (!found || busy !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_find found=%0d busy=%b want 1/1",
               found, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (seg !== 7'h00 || digit_idx !== 2'd0 || dp !== 1'b0 ||
        busy !== 1'b0 || c_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_async seg=%b idx=%0d dp=%b busy=%b rdy=%b want 0/0/0/0/1",
               seg, digit_idx, dp, busy, c_ready);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    m_busy = 1'b0;
    m_n = 0;
    m_snap = 16'h0000;
    repeat (3) cycle();
    total++;
    if (busy !== 1'b0 || c_ready !== 1'b1 || seg !== 7'h00) begin
      bad++;
      $display("FAIL rstmid_idle busy=%b rdy=%b seg=%b want 0/1/0",
               busy, c_ready, seg);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    m_busy = 1'b0;
    m_n = 0;
    m_snap = 16'h0000;
    m_hs = 1'b0;
    rst_n = 1'b0;
    c_valid = 1'b0;
    c_data = 16'h0000;
    hold = 1'b0;
    test_reset();
    test_scan();
    test_out_of_range();
    test_reload();
    test_hold();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
